// File: rtl/comms_bus_arbiter_pkg.sv
// Shared types and opcode constants for the core-bus arbiter.
package comms_bus_arbiter_pkg;

  localparam logic [7:0] WRITE = 8'h02;
  localparam logic [7:0] READ  = 8'h03;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUS     = 2'd1,
    ARB_RESPOND = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_HOST = 1'b0,
    OWNER_CORE = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating acknowledge-wait counter; expired flags the last permitted bus cycle.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Count bus cycles, holding at the limit instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LIMIT)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Current cycle is the TIMEOUT_CYCLES-th one with bus_req high.
  assign expired = (count_r >= LAST);

endmodule

// File: rtl/comms_bus_arbiter.sv
// Round-robin arbiter serialising host and core requests onto the shared core bus,
// with acknowledge timeout and per-requester response return.
module comms_bus_arbiter
  import comms_bus_arbiter_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 8,
  parameter int ADDRESS_WIDTH     = 24,
  parameter int VALUE_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         host_valid,
  output logic                         host_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] host_instruction,
  input  logic [ADDRESS_WIDTH-1:0]     host_address,
  input  logic [VALUE_WIDTH-1:0]       host_value,
  output logic                         host_rsp_valid,
  output logic                         host_rsp_error,
  output logic [VALUE_WIDTH-1:0]       host_rsp_value,
  input  logic                         core_req,
  input  logic                         core_we,
  input  logic [ADDRESS_WIDTH-1:0]     core_address,
  input  logic [VALUE_WIDTH-1:0]       core_wdata,
  output logic                         core_gnt,
  output logic                         core_rvalid,
  output logic                         core_rerror,
  output logic [VALUE_WIDTH-1:0]       core_rdata,
  output logic                         bus_req,
  output logic                         bus_we,
  output logic [ADDRESS_WIDTH-1:0]     bus_address,
  output logic [VALUE_WIDTH-1:0]       bus_wdata,
  input  logic                         bus_ack,
  input  logic [VALUE_WIDTH-1:0]       bus_rdata
);

  localparam logic [INSTRUCTION_WIDTH-1:0] OP_WRITE = INSTRUCTION_WIDTH'(WRITE);
  localparam logic [INSTRUCTION_WIDTH-1:0] OP_READ  = INSTRUCTION_WIDTH'(READ);

  arb_state_t               state_r, next_state_s;
  arb_owner_t               last_grant_r, next_last_grant_s;
  arb_owner_t               owner_r, next_owner_s;
  logic                     we_r, next_we_s;
  logic [ADDRESS_WIDTH-1:0] address_r, next_address_s;
  logic [VALUE_WIDTH-1:0]   wdata_r, next_wdata_s;
  logic                     bus_req_r;

  logic                     host_wins_s;
  logic                     host_ready_s, core_gnt_s;
  logic                     cnt_clear_s, cnt_enable_s, expired_s;
  logic                     rsp_fire_s, rsp_error_s;
  logic [VALUE_WIDTH-1:0]   rsp_value_s;

  logic                     host_rsp_valid_r, host_rsp_error_r;
  logic [VALUE_WIDTH-1:0]   host_rsp_value_r;
  logic                     core_rvalid_r, core_rerror_r;
  logic [VALUE_WIDTH-1:0]   core_rdata_r;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear_s),
    .enable (cnt_enable_s),
    .expired(expired_s)
  );

  // On a tie the requester that was not served last wins.
  assign host_wins_s = host_valid && (!core_req || (last_grant_r == OWNER_CORE));

  // Next-state, acceptance and completion decode.
  always_comb begin
    next_state_s      = state_r;
    next_last_grant_s = last_grant_r;
    next_owner_s      = owner_r;
    next_we_s         = we_r;
    next_address_s    = address_r;
    next_wdata_s      = wdata_r;
    host_ready_s      = 1'b0;
    core_gnt_s        = 1'b0;
    cnt_clear_s       = 1'b1;
    cnt_enable_s      = 1'b0;
    rsp_fire_s        = 1'b0;
    rsp_error_s       = 1'b0;
    rsp_value_s       = '0;
    case (state_r)
      ARB_IDLE: begin
        if (host_wins_s) begin
          host_ready_s      = 1'b1;
          next_owner_s      = OWNER_HOST;
          next_last_grant_s = OWNER_HOST;
          next_address_s    = host_address;
          next_wdata_s      = host_value;
          if (host_instruction == OP_WRITE) begin
            next_we_s    = 1'b1;
            next_state_s = ARB_BUS;
          end else if (host_instruction == OP_READ) begin
            next_we_s    = 1'b0;
            next_state_s = ARB_BUS;
          end else begin
            // Illegal opcode: answer with an error without touching the bus.
            next_we_s    = 1'b0;
            next_state_s = ARB_RESPOND;
            rsp_fire_s   = 1'b1;
            rsp_error_s  = 1'b1;
          end
        end else if (core_req) begin
          core_gnt_s        = 1'b1;
          next_owner_s      = OWNER_CORE;
          next_last_grant_s = OWNER_CORE;
          next_we_s         = core_we;
          next_address_s    = core_address;
          next_wdata_s      = core_wdata;
          next_state_s      = ARB_BUS;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      ARB_BUS: begin
        cnt_clear_s  = 1'b0;
        cnt_enable_s = 1'b1;
        // An ack on the final permitted cycle still counts as success.
        if (bus_ack) begin
          rsp_fire_s   = 1'b1;
          rsp_value_s  = we_r ? '0 : bus_rdata;
          next_state_s = ARB_RESPOND;
        end else if (expired_s) begin
          rsp_fire_s   = 1'b1;
          rsp_error_s  = 1'b1;
          next_state_s = ARB_RESPOND;
        end else begin
          next_state_s = ARB_BUS;
        end
      end
      ARB_RESPOND: begin
        next_state_s = ARB_IDLE;
      end
      default: begin
        next_state_s = ARB_IDLE;
      end
    endcase
  end

  // Arbiter state, transaction latch and bus drive registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ARB_IDLE;
      last_grant_r <= OWNER_CORE;
      owner_r      <= OWNER_HOST;
      we_r         <= 1'b0;
      address_r    <= '0;
      wdata_r      <= '0;
      bus_req_r    <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      last_grant_r <= next_last_grant_s;
      owner_r      <= next_owner_s;
      we_r         <= next_we_s;
      address_r    <= next_address_s;
      wdata_r      <= next_wdata_s;
      bus_req_r    <= (next_state_s == ARB_BUS);
    end
  end

  // Response registers; data and error hold until that port's next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rsp_valid_r <= 1'b0;
      host_rsp_error_r <= 1'b0;
      host_rsp_value_r <= '0;
      core_rvalid_r    <= 1'b0;
      core_rerror_r    <= 1'b0;
      core_rdata_r     <= '0;
    end else begin
      host_rsp_valid_r <= rsp_fire_s && (next_owner_s == OWNER_HOST);
      core_rvalid_r    <= rsp_fire_s && (next_owner_s == OWNER_CORE);
      if (rsp_fire_s && (next_owner_s == OWNER_HOST)) begin
        host_rsp_error_r <= rsp_error_s;
        host_rsp_value_r <= rsp_value_s;
      end else begin
        host_rsp_error_r <= host_rsp_error_r;
        host_rsp_value_r <= host_rsp_value_r;
      end
      if (rsp_fire_s && (next_owner_s == OWNER_CORE)) begin
        core_rerror_r <= rsp_error_s;
        core_rdata_r  <= rsp_value_s;
      end else begin
        core_rerror_r <= core_rerror_r;
        core_rdata_r  <= core_rdata_r;
      end
    end
  end

  // Handshakes are combinational but forced low while reset is held.
  assign host_ready     = host_ready_s & rst_n;
  assign core_gnt       = core_gnt_s & rst_n;
  assign bus_req        = bus_req_r;
  assign bus_we         = we_r;
  assign bus_address    = address_r;
  assign bus_wdata      = wdata_r;
  assign host_rsp_valid = host_rsp_valid_r;
  assign host_rsp_error = host_rsp_error_r;
  assign host_rsp_value = host_rsp_value_r;
  assign core_rvalid    = core_rvalid_r;
  assign core_rerror    = core_rerror_r;
  assign core_rdata     = core_rdata_r;

endmodule

// File: tb/tb_comms_bus_arbiter.sv
// Self-checking bench for comms_bus_arbiter: directed table, tie/reset sequences
// and randomized rounds scored against a transaction-level model.
module tb_comms_bus_arbiter;
  import comms_bus_arbiter_pkg::*;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_valid, host_ready;
  logic [7:0]  host_instruction;
  logic [23:0] host_address;
  logic [31:0] host_value;
  logic        host_rsp_valid, host_rsp_error;
  logic [31:0] host_rsp_value;
  logic        core_req, core_we, core_gnt, core_rvalid, core_rerror;
  logic [23:0] core_address;
  logic [31:0] core_wdata, core_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [23:0] bus_address;
  logic [31:0] bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  comms_bus_arbiter #(
    .INSTRUCTION_WIDTH(8), .ADDRESS_WIDTH(24), .VALUE_WIDTH(32), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_valid(host_valid), .host_ready(host_ready), .host_instruction(host_instruction),
    .host_address(host_address), .host_value(host_value),
    .host_rsp_valid(host_rsp_valid), .host_rsp_error(host_rsp_error), .host_rsp_value(host_rsp_value),
    .core_req(core_req), .core_we(core_we), .core_address(core_address), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rerror(core_rerror), .core_rdata(core_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  int checks = 0;
  int errors = 0;

  // Requester-side view: pending commands and the model's round-robin pointer.
  arb_owner_t  model_last;
  bit          host_pend, core_pend;
  logic [7:0]  h_instr;
  logic [23:0] h_addr, c_addr;
  logic [31:0] h_wdata, h_rdata, c_wdata, c_rdata;
  logic        c_we;
  int          h_delay, c_delay;

  typedef struct {
    bit          is_host;
    logic [7:0]  op;
    logic        we;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    bit          exp_err;
    logic [31:0] exp_val;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_host(input logic [7:0] op, input logic [23:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int d);
    host_pend = 1'b1; h_instr = op; h_addr = a; h_wdata = wd; h_rdata = rd; h_delay = d;
  endtask

  task automatic set_core(input logic we, input logic [23:0] a, input logic [31:0] wd,
                          input logic [31:0] rd, input int d);
    core_pend = 1'b1; c_we = we; c_addr = a; c_wdata = wd; c_rdata = rd; c_delay = d;
  endtask

  // One arbitration round: present pending requests, check the grant, play the
  // target (ack after 'delay' bus cycles) and check the whole response.
  task automatic do_round(input bit use_tbl, input bit t_err, input logic [31:0] t_val,
                          input int t_cyc, output bit won_host);
    bit exp_host, legal, is_wr, m_err, seen;
    logic [23:0] e_addr;
    logic [31:0] e_wdata, rd, m_val;
    int dly, m_cyc, bus_cyc;
    @(posedge clk); #1;
    host_valid = host_pend; host_instruction = h_instr; host_address = h_addr; host_value = h_wdata;
    core_req = core_pend; core_we = c_we; core_address = c_addr; core_wdata = c_wdata;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    exp_host = host_pend && (!core_pend || model_last == OWNER_CORE);
    @(negedge clk);
    chk("grant_host", 64'(host_ready), 64'(exp_host));
    chk("grant_core", 64'(core_gnt), 64'(!exp_host));
    won_host = host_ready;
    model_last = exp_host ? OWNER_HOST : OWNER_CORE;
    if (exp_host) begin
      legal = (h_instr == WRITE) || (h_instr == READ);
      is_wr = (h_instr == WRITE);
      e_addr = h_addr; e_wdata = h_wdata; rd = h_rdata; dly = h_delay;
    end else begin
      legal = 1'b1; is_wr = c_we;
      e_addr = c_addr; e_wdata = c_wdata; rd = c_rdata; dly = c_delay;
    end
    if (!legal) begin
      m_err = 1'b1; m_val = 32'h0; m_cyc = 0;
    end else if (dly < T) begin
      m_err = 1'b0; m_val = is_wr ? 32'h0 : rd; m_cyc = dly + 1;
    end else begin
      m_err = 1'b1; m_val = 32'h0; m_cyc = T;
    end
    if (use_tbl) begin
      m_err = t_err; m_val = t_val; m_cyc = t_cyc;
    end
    @(posedge clk); #1;
    if (exp_host) begin host_valid = 1'b0; host_pend = 1'b0; end
    else begin core_req = 1'b0; core_pend = 1'b0; end
    bus_cyc = 0;
    seen = 1'b0;
    for (int k = 0; k < T + 4 && !seen; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      // Stray acks outside the bus phase must be ignored.
      bus_ack = (k == dly) || (!legal && k == 0);
      bus_rdata = (k == dly) ? rd : (32'hBAD0_0000 | 32'(k));
      @(negedge clk);
      chk("stall_ready", 64'(host_ready), 64'(0));
      chk("stall_gnt", 64'(core_gnt), 64'(0));
      chk("other_valid", 64'(exp_host ? core_rvalid : host_rsp_valid), 64'(0));
      if (bus_req) begin
        bus_cyc++;
        chk("bus_we", 64'(bus_we), 64'(is_wr));
        chk("bus_addr", 64'(bus_address), 64'(e_addr));
        if (is_wr) chk("bus_wdata", 64'(bus_wdata), 64'(e_wdata));
      end
      if (exp_host ? host_rsp_valid : core_rvalid) begin
        seen = 1'b1;
        chk("rsp_error", 64'(exp_host ? host_rsp_error : core_rerror), 64'(m_err));
        chk("rsp_value", 64'(exp_host ? host_rsp_value : core_rdata), 64'(m_val));
        chk("rsp_latency", 64'(k), 64'(m_cyc));
        chk("rsp_busreq_low", 64'(bus_req), 64'(0));
      end
    end
    chk("rsp_seen", 64'(seen), 64'(1));
    chk("bus_cycles", 64'(bus_cyc), 64'(m_cyc));
  endtask

  initial begin
    bit w;
    rst_n = 1'b0;
    host_valid = 1'b0; host_instruction = 8'h0; host_address = 24'h0; host_value = 32'h0;
    core_req = 1'b0; core_we = 1'b0; core_address = 24'h0; core_wdata = 32'h0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    host_pend = 1'b0; core_pend = 1'b0; model_last = OWNER_CORE;
    h_instr = 8'h0; h_addr = 24'h0; h_wdata = 32'h0; h_rdata = 32'h0; h_delay = 0;
    c_we = 1'b0; c_addr = 24'h0; c_wdata = 32'h0; c_rdata = 32'h0; c_delay = 0;

    vecs[0] = '{1'b1, WRITE, 1'b0, 24'h000010, 32'hCAFEBABE, 32'h0, 1, 1'b0, 32'h0, 2};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 24'h000020, 32'h0, 32'h12345678, 0, 1'b0, 32'h12345678, 1};
    vecs[2] = '{1'b1, READ, 1'b0, 24'h000030, 32'h0, 32'h55555555, 99, 1'b1, 32'h0, 4};
    vecs[3] = '{1'b1, 8'h04, 1'b0, 24'h000040, 32'h11111111, 32'h0, 0, 1'b1, 32'h0, 0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 24'h000050, 32'h0BADF00D, 32'h0, 3, 1'b0, 32'h0, 4};
    vecs[5] = '{1'b1, READ, 1'b0, 24'h000060, 32'h0, 32'hA5A55A5A, 3, 1'b0, 32'hA5A55A5A, 4};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 24'hFFFFFF, 32'h0, 32'h77777777, 99, 1'b1, 32'h0, 4};

    // Reset state.
    #23;
    chk("rst_bus_req", 64'(bus_req), 64'(0));
    chk("rst_bus_fields", 64'({bus_we, bus_address, bus_wdata}), 64'(0));
    chk("rst_host", 64'({host_ready, host_rsp_valid, host_rsp_error, host_rsp_value}), 64'(0));
    chk("rst_core", 64'({core_gnt, core_rvalid, core_rerror, core_rdata}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Simultaneous requests from reset: host, core, host.
    set_host(WRITE, 24'h000100, 32'h01010101, 32'h0, 0);
    set_core(1'b0, 24'h000200, 32'h0, 32'h02020202, 0);
    do_round(1'b0, 1'b0, 32'h0, 0, w);
    chk("tie1_host", 64'(w), 64'(1));
    set_host(READ, 24'h000104, 32'h0, 32'h03030303, 1);
    do_round(1'b0, 1'b0, 32'h0, 0, w);
    chk("tie2_core", 64'(w), 64'(0));
    set_core(1'b1, 24'h000204, 32'h04040404, 32'h0, 2);
    do_round(1'b0, 1'b0, 32'h0, 0, w);
    chk("tie3_host", 64'(w), 64'(1));

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      host_pend = 1'b0; core_pend = 1'b0;
      if (vecs[i].is_host) set_host(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].delay);
      else set_core(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].delay);
      do_round(1'b1, vecs[i].exp_err, vecs[i].exp_val, vecs[i].exp_cycles, w);
      chk("tbl_owner", 64'(w), 64'(vecs[i].is_host));
    end

    // Randomized rounds; a losing requester keeps its command pending.
    host_pend = 1'b0; core_pend = 1'b0;
    for (int i = 0; i < 80; i++) begin
      logic [7:0] op;
      if (!host_pend && ($urandom_range(0, 1) == 1)) begin
        case ($urandom_range(0, 4))
          0, 1:    op = WRITE;
          2, 3:    op = READ;
          default: op = 8'($urandom);
        endcase
        set_host(op, 24'($urandom), $urandom, $urandom, $urandom_range(0, T + 1));
      end
      if (!core_pend && ($urandom_range(0, 1) == 1))
        set_core(1'($urandom), 24'($urandom), $urandom, $urandom, $urandom_range(0, T + 1));
      if (!host_pend && !core_pend)
        set_core(1'b0, 24'($urandom), $urandom, $urandom, $urandom_range(0, T + 1));
      do_round(1'b0, 1'b0, 32'h0, 0, w);
    end

    // Reset in the middle of a bus cycle: no response, then a clean restart.
    @(posedge clk); #1;
    host_valid = 1'b1; host_instruction = WRITE; host_address = 24'h000ABC; host_value = 32'hDEADBEEF;
    core_req = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
    host_valid = 1'b0;
    @(posedge clk); #1;
    chk("midbus_req_high", 64'(bus_req), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("midbus_req_drop", 64'(bus_req), 64'(0));
    @(posedge clk); @(posedge clk); #1;
    chk("midbus_no_rsp", 64'({host_rsp_valid, core_rvalid}), 64'(0));
    rst_n = 1'b1;
    model_last = OWNER_CORE; host_pend = 1'b0; core_pend = 1'b0;
    set_host(WRITE, 24'h000ABC, 32'hDEADBEEF, 32'h0, 1);
    do_round(1'b1, 1'b0, 32'h0, 2, w);
    chk("post_rst_owner", 64'(w), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/comms_bus_arbiter.md
# comms_bus_arbiter

Two-requester arbiter and sequencer for the shared memory-mapped core bus. It sits between the SPI command decoder (the host port, carrying decoded instruction/address/value) and the compute core's own register-access port. It serialises both onto one target bus with round-robin fairness and an acknowledge timeout, and returns read data and status to whichever requester owns the transaction.

## Interface
- `INSTRUCTION_WIDTH`, 8: width of the host opcode.
- `ADDRESS_WIDTH`, 24: bus address width.
- `VALUE_WIDTH`, 32: bus data width.
- `TIMEOUT_CYCLES`, 255: maximum cycles `bus_req` is held without `bus_ack` before abort; legal range ≥1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `host_valid` in 1: host command present.
- `host_ready` out 1: host command accepted this cycle when `host_valid` is also high.
- `host_instruction` in INSTRUCTION_WIDTH: opcode, `WRITE` or `READ`.
- `host_address` in ADDRESS_WIDTH: target address.
- `host_value` in VALUE_WIDTH: write data.
- `host_rsp_valid` out 1: one-cycle response pulse.
- `host_rsp_error` out 1: qualifies `host_rsp_valid`; set for timeout or illegal opcode.
- `host_rsp_value` out VALUE_WIDTH: read data; 0 on write or error.
- `core_req` in 1: core access request, level, held until `core_gnt`.
- `core_we` in 1: core write enable.
- `core_address` in ADDRESS_WIDTH: core target address.
- `core_wdata` in VALUE_WIDTH: core write data.
- `core_gnt` out 1: one-cycle acceptance pulse.
- `core_rvalid` out 1: one-cycle completion pulse.
- `core_rerror` out 1: timeout flag, qualifies `core_rvalid`.
- `core_rdata` out VALUE_WIDTH: core read data.
- `bus_req` out 1: transaction active.
- `bus_we` out 1: write enable.
- `bus_address` out ADDRESS_WIDTH: bus address.
- `bus_wdata` out VALUE_WIDTH: bus write data.
- `bus_ack` in 1: target completion, sampled only while `bus_req` is high.
- `bus_rdata` in VALUE_WIDTH: read data, valid with `bus_ack`.

## Operation
- States: `IDLE`, `BUS`, `RESPOND`.
- **IDLE**
  - Arbitrate between `host_valid` and `core_req`.
  - If both are requesting, the grant goes to the requester not granted last (`last_grant` bit). `last_grant` resets to CORE, so the host wins the first tie.
  - `host_ready` and `core_gnt` are combinational in IDLE: high only for the arbitration winner with a pending request.
- **Acceptance**
  - Latch owner, `we`, address and data into internal registers.
  - Update `last_grant`.
  - Host opcode `WRITE` sets `we`=1; `READ` sets `we`=0.
  - Any other host opcode is accepted but skips BUS: go to RESPOND with error=1, value=0, and no bus cycle.
- **BUS**
  - `bus_req`=1 with registered, stable `bus_we`, `bus_address` and `bus_wdata`.
  - The timeout counter increments each cycle.
  - On `bus_ack`: capture `bus_rdata` (reads only), clear the error flag, go to RESPOND.
  - When the counter reaches `TIMEOUT_CYCLES` without an ack: drop `bus_req`, set error=1, data=0, go to RESPOND.
  - An ack arriving in the same cycle the counter hits the limit counts as success.
- **RESPOND**
  - Pulse the owner's `*_rsp_valid`/`core_rvalid` with error and data.
  - Clear the counter, return to IDLE.
  - The non-owner response outputs stay 0.
- **Response data**: held until the next response of the same port. It is only meaningful while valid is high.

## Timing
- Reset (async assert, sync-release behaviour, with flops cleared immediately):
  - State = IDLE, `last_grant` = CORE.
  - All outputs 0: `bus_req`, `bus_we`, `bus_address`, `bus_wdata`, rsp/rvalid, error, data, `host_ready`, `core_gnt`.
  - A reset mid-BUS drops `bus_req` without a response; the requester must reissue.
- Accept at cycle N → `bus_req` high from N+1.
- Ack sampled at cycle M ≥ N+1 → response pulse at M+1 → IDLE at M+2. Next accept no earlier than M+2.
- Minimum host turnaround is 3 cycles: accept, bus with immediate ack, respond.
- Illegal opcode: accept at N, error response at N+1.
- Timeout: `bus_req` is high for exactly `TIMEOUT_CYCLES` cycles (N+1 … N+TIMEOUT_CYCLES), then the error response follows in the next cycle.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)`. It saturates and never wraps.
- `bus_ack` outside BUS is ignored.
- Both requesters are stalled while a transaction is in flight; there is no queuing.

## Structure
- Add to the `TitanComms` package:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_BUS, ARB_RESPOND} arb_state_t`
  - `typedef enum logic {OWNER_HOST, OWNER_CORE} arb_owner_t`
  - Reuse the existing `WRITE`/`READ` opcode constants.
- One sub-module: `bus_timeout_counter` (clear, enable, saturating count, `expired` output), parameterised by `TIMEOUT_CYCLES`.
- Everything else lives in `comms_bus_arbiter`.

## Test plan
- **Host write**: `WRITE`, addr 0x000010, value 0xCAFEBABE, ack after 2 cycles → bus shows we=1/0x000010/0xCAFEBABE for 2 cycles; `host_rsp_valid` pulse with error=0, value=0.
- **Core read**: addr 0x000020, `bus_rdata`=0x12345678 with immediate ack → `core_gnt` pulse, `core_rvalid` 2 cycles later with `core_rdata`=0x12345678.
- **Simultaneous requests from reset**: host is served first, then core. Hold both asserted → grants alternate host/core/host.
- **Timeout**: `TIMEOUT_CYCLES`=4, host `READ`, no ack → `bus_req` high exactly 4 cycles, then `host_rsp_error`=1, value=0; arbiter returns to IDLE.
- **Illegal opcode**: host opcode 0x04 → no `bus_req`; error response the cycle after accept.
- **Reset mid-BUS**: assert `rst_n`=0 during BUS → `bus_req` falls asynchronously and no response pulse appears. After release, a fresh `WRITE` completes normally.
